// File: rtl/tone_sequencer.sv
// Queued square-wave note player: requests land in a small FIFO. Each note plays for
// cur_dur milliseconds at a programmable half-period, then a silent gap follows.
module tone_sequencer #(
  parameter int CLK_PER_MS  = 100000,
  parameter int QUEUE_DEPTH = 4,
  parameter int DIV_W       = 20,
  parameter int DUR_W       = 16,
  parameter int GAP_MS      = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [DIV_W-1:0]               req_half_period,
  input  logic [DUR_W-1:0]               req_duration_ms,
  input  logic                           stop,
  output logic                           tone_out,
  output logic                           busy,
  output logic                           note_done,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = (GAP_MS > 0) ? DUR_W'(GAP_MS - 1) : '0;
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [DUR_W-1:0]   ms_q, ms_d;
  logic [DIV_W-1:0]   hc_q, hc_d;
  logic               tone_q, tone_d;
  logic               note_done_q, note_done_d;
  logic [DIV_W-1:0]   cur_half_q, cur_half_d;
  logic [DUR_W-1:0]   cur_dur_q, cur_dur_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DIV_W-1:0]   mem_half_q [QUEUE_DEPTH];
  logic [DUR_W-1:0]   mem_dur_q  [QUEUE_DEPTH];

  logic               push, pop;
  logic [DIV_W-1:0]   head_half;
  logic [DUR_W-1:0]   head_dur;
  logic               pre_wrap;

  // Ready looks only at the registered count, so a simultaneous pop never frees a slot early.
  assign req_ready   = (count_q < DEPTH) && !stop;
  assign push        = req_valid && req_ready;
  assign head_half   = mem_half_q[rd_ptr_q];
  assign head_dur    = mem_dur_q[rd_ptr_q];
  assign pre_wrap    = (pre_q == PRE_LAST);

  assign tone_out    = tone_q;
  assign note_done   = note_done_q;
  assign queue_count = count_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    ms_d       = ms_q;
    hc_d       = hc_q;
    tone_d     = tone_q;
    cur_half_d = cur_half_q;
    cur_dur_d  = cur_dur_q;
    pop        = 1'b0;

    if (stop) begin
      state_d = IDLE;
      pre_d   = '0;
      ms_d    = '0;
      hc_d    = '0;
      tone_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tone_d = 1'b0;
          if (count_q != '0) begin
            pop        = 1'b1;
            cur_half_d = head_half;
            cur_dur_d  = head_dur;
            pre_d      = '0;
            ms_d       = '0;
            hc_d       = '0;
            if (head_dur != '0) state_d = PLAY;
          end
        end
        PLAY: begin
          if (pre_wrap) begin
            pre_d = '0;
            ms_d  = ms_q + DUR_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
          if (cur_half_q == '0) begin
            tone_d = 1'b0;
            hc_d   = '0;
          end else if (hc_q == cur_half_q - DIV_W'(1)) begin
            tone_d = ~tone_q;
            hc_d   = '0;
          end else begin
            hc_d   = hc_q + DIV_W'(1);
          end
          if (pre_wrap && (ms_q == cur_dur_q - DUR_W'(1))) begin
            state_d = (GAP_MS > 0) ? GAP : IDLE;
            tone_d  = 1'b0;
            pre_d   = '0;
            ms_d    = '0;
            hc_d    = '0;
          end
        end
        GAP: begin
          tone_d = 1'b0;
          if (pre_wrap) begin
            pre_d = '0;
            ms_d  = ms_q + DUR_W'(1);
            if (ms_q == GAP_LAST) begin
              state_d = IDLE;
              ms_d    = '0;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Registered pulse that lands on the last PLAY cycle, or right after a zero-length pop.
    note_done_d = (pop && (head_dur == '0)) ||
                  ((state_d == PLAY) && (pre_d == PRE_LAST) &&
                   (ms_d == cur_dur_d - DUR_W'(1)));
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (stop) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      ms_q        <= '0;
      hc_q        <= '0;
      tone_q      <= 1'b0;
      note_done_q <= 1'b0;
      cur_half_q  <= '0;
      cur_dur_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      ms_q        <= ms_d;
      hc_q        <= hc_d;
      tone_q      <= tone_d;
      note_done_q <= note_done_d;
      cur_half_q  <= cur_half_d;
      cur_dur_q   <= cur_dur_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Queue storage carries only data; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_half_q[wr_ptr_q] <= req_half_period;
      mem_dur_q[wr_ptr_q]  <= req_duration_ms;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: cycle-accurate vector table for single notes,
// plus hand-written sequences for queue-full, stop and asynchronous reset.
module tb_tone_sequencer;
  localparam int CLK_PER_MS  = 10;
  localparam int QUEUE_DEPTH = 4;
  localparam int DIV_W       = 20;
  localparam int DUR_W       = 16;
  localparam int GAP_MS      = 1;
  localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1;

  logic               clock = 1'b0;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic [DIV_W-1:0]   req_half_period;
  logic [DUR_W-1:0]   req_duration_ms;
  logic               stop;
  logic               tone_out;
  logic               busy;
  logic               note_done;
  logic [CNT_W-1:0]   queue_count;

  always #5 clock = ~clock;

  tone_sequencer #(
    .CLK_PER_MS (CLK_PER_MS),
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .DIV_W      (DIV_W),
    .DUR_W      (DUR_W),
    .GAP_MS     (GAP_MS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_half_period(req_half_period),
    .req_duration_ms(req_duration_ms),
    .stop           (stop),
    .tone_out       (tone_out),
    .busy           (busy),
    .note_done      (note_done),
    .queue_count    (queue_count)
  );

  typedef struct {
    logic valid;
    int   half;
    int   dur;
    logic tone;
    logic done;
    logic bsy;
    int   count;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  function automatic void add(input logic valid, input int half, input int dur,
                              input logic tone, input logic done, input logic bsy,
                              input int count);
    vec_t v;
    v.valid = valid; v.half = half; v.dur = dur;
    v.tone = tone; v.done = done; v.bsy = bsy; v.count = count;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic valid, input int half, input int dur);
    req_valid       = valid;
    req_half_period = DIV_W'(half);
    req_duration_ms = DUR_W'(dur);
  endtask

  initial begin
    int t;
    int dcnt;
    int bcnt;
    int pulse_t[$];
    int exp_gap[4];

    exp_gap = '{31, 41, 21, 31};

    // Test 1: one note {3,2}: push, 20 PLAY cycles, 10 gap cycles, idle
    add(1, 3, 2, 0, 0, 1, 1);
    for (int k = 1; k <= 20; k++) add(0, 0, 0, logic'(((k - 1) / 3) % 2), logic'(k == 20), 1, 0);
    for (int g = 1; g <= 10; g++) add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // Test 3: rest then half=1 note
    add(1, 0, 1, 0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 1, 1);
    for (int k = 2; k <= 10; k++) add(0, 0, 0, 0, logic'(k == 10), 1, 1);
    for (int g = 1; g <= 10; g++) add(0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 10; k++) add(0, 0, 0, logic'((k - 1) % 2), logic'(k == 10), 1, 0);
    for (int g = 1; g <= 10; g++) add(0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // Test 4: zero-duration note
    add(1, 2, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    stop  = 1'b0;
    drive(0, 0, 0);
    #12;
    chk("reset tone", tone_out, 0);
    chk("reset done", note_done, 0);
    chk("reset count", queue_count, 0);
    chk("reset busy", busy, 0);
    chk("reset ready", req_ready, 1);
    @(negedge clock) reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].half, vecs[i].dur);
      step();
      chk($sformatf("vec%0d tone", i), tone_out, vecs[i].tone);
      chk($sformatf("vec%0d done", i), note_done, vecs[i].done);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
      chk($sformatf("vec%0d count", i), queue_count, vecs[i].count);
    end
    drive(0, 0, 0);

    // Test 2: five requests pushed while a note is playing
    drive(1, 1, 1); step();
    drive(1, 1, 1); step();
    chk("t2 first pop count", queue_count, 1);
    chk("t2 first pop busy", busy, 1);
    drive(1, 1, 2); step();
    drive(1, 1, 3); step();
    drive(1, 1, 1); step();
    chk("t2 full count", queue_count, 4);
    drive(1, 1, 2);
    chk("t2 fifth held", req_ready, 0);
    t = 0;
    while (!req_ready && t < 200) begin
      step();
      t++;
    end
    chk("t2 fifth wait bounded", int'(t < 200), 1);
    chk("t2 count at release", queue_count, 3);
    step();
    drive(0, 0, 0);
    chk("t2 fifth accepted", queue_count, 4);
    t = 0;
    while (busy && t < 2000) begin
      step();
      t++;
      if (note_done) pulse_t.push_back(t);
    end
    chk("t2 drain bounded", int'(t < 2000), 1);
    chk("t2 done count", pulse_t.size(), 5);
    if (pulse_t.size() == 5) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("t2 interval%0d", i), pulse_t[i+1] - pulse_t[i], exp_gap[i]);
    end

    // Test 5: stop mid-PLAY with queued entries and a concurrent request
    drive(1, 2, 3); step();
    drive(1, 1, 1); step();
    step();
    drive(0, 0, 0);
    repeat (5) step();
    chk("t5 tone before stop", tone_out, 1);
    chk("t5 count before stop", queue_count, 2);
    stop = 1'b1;
    drive(1, 1, 1);
    #1;
    chk("t5 ready during stop", req_ready, 0);
    step();
    stop = 1'b0;
    drive(0, 0, 0);
    chk("t5 busy", busy, 0);
    chk("t5 count", queue_count, 0);
    chk("t5 tone", tone_out, 0);
    chk("t5 done", note_done, 0);
    dcnt = 0;
    bcnt = 0;
    repeat (40) begin
      step();
      if (note_done) dcnt++;
      if (busy) bcnt++;
    end
    chk("t5 no done after stop", dcnt, 0);
    chk("t5 stays idle", bcnt, 0);

    // Test 6: asynchronous reset while tone_out is high
    drive(1, 2, 5); step();
    drive(1, 1, 1); step();
    drive(0, 0, 0);
    t = 0;
    while (!tone_out && t < 100) begin
      step();
      t++;
    end
    chk("t6 tone high", tone_out, 1);
    chk("t6 count", queue_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6 async tone", tone_out, 0);
    chk("t6 async count", queue_count, 0);
    chk("t6 async busy", busy, 0);
    chk("t6 async done", note_done, 0);
    @(negedge clock) reset = 1'b0;
    step();
    drive(1, 1, 1); step();
    drive(0, 0, 0);
    chk("t6 post count", queue_count, 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("t6 play%0d tone", k), tone_out, (k - 1) % 2);
      chk($sformatf("t6 play%0d done", k), note_done, int'(k == 10));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
